baud_gen_sel: RTL and testbench

//  Runtime-selectable UART baud-rate generator; successor to the fixed-9600 divider.

---
 rtl/baud_gen_sel.sv | 150 +++++++++++++++
 tb/tb_baud_gen_sel.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_sel.sv
// Runtime-selectable UART baud generator: mid-bit, end-of-bit and frame-done strobes, optional 16x tick.
// Latency: first clk_bps is registered HALF+2 edges after bps_start is first sampled high; period DIV+1.
// No backpressure: bps_start is a run level; dropping it clears the generator on the next edge.
// Optional feature macro: BAUD_OVS16_EN (16x oversample tick on os_tick; tied low when undefined).
module baud_gen_sel #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FRAME_BITS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bps_start,
  input  logic [2:0] baud_sel,
  output logic       clk_bps,
  output logic       bit_end,
  output logic       frame_done,
  output logic [3:0] bit_idx,
  output logic       os_tick
);

  // Divisors per baud table entry: DIV = CLK_HZ/baud - 1
  localparam logic [CNT_W-1:0] DIV_9600   = CNT_W'(CLK_HZ / 9600 - 1);
  localparam logic [CNT_W-1:0] DIV_19200  = CNT_W'(CLK_HZ / 19200 - 1);
  localparam logic [CNT_W-1:0] DIV_38400  = CNT_W'(CLK_HZ / 38400 - 1);
  localparam logic [CNT_W-1:0] DIV_57600  = CNT_W'(CLK_HZ / 57600 - 1);
  localparam logic [CNT_W-1:0] DIV_115200 = CNT_W'(CLK_HZ / 115200 - 1);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
  localparam logic [3:0]       LAST_BIT   = 4'(FRAME_BITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] div_sel, half_sel;
  logic [CNT_W-1:0] div_r, half_r;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       bit_idx_nxt;
  logic             counting, at_half, at_wrap, at_last, start_evt;

  // Divisor lookup for the currently requested rate; unlisted codes fall back to 9600
  always_comb begin
    div_sel = DIV_9600;
    case (baud_sel)
      3'd1:    div_sel = DIV_19200;
      3'd2:    div_sel = DIV_38400;
      3'd3:    div_sel = DIV_57600;
      3'd4:    div_sel = DIV_115200;
      default: div_sel = DIV_9600;
    endcase
    half_sel = div_sel >> 1;
  end

  assign counting  = (state == RUN) && bps_start;
  assign start_evt = (state == IDLE) && bps_start;
  assign at_half   = counting && (cnt == half_r);
  assign at_wrap   = counting && (cnt == div_r);
  assign at_last   = (bit_idx == LAST_BIT);

  // Next-state: run while bps_start is high, fall back to IDLE as soon as it drops
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bps_start) state_nxt = RUN;
      RUN:     if (!bps_start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Divider and bit counter: both sit at zero unless actively counting
  always_comb begin
    cnt_nxt     = '0;
    bit_idx_nxt = '0;
    if (counting) begin
      cnt_nxt     = at_wrap ? '0 : cnt + ONE_C;
      bit_idx_nxt = bit_idx;
      if (at_wrap) bit_idx_nxt = at_last ? 4'd0 : bit_idx + 4'd1;
    end
  end

  // State register; rate is frozen at IDLE->RUN so mid-run baud_sel changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      div_r  <= '0;
      half_r <= '0;
    end else begin
      state <= state_nxt;
      if (start_evt) begin
        div_r  <= div_sel;
        half_r <= half_sel;
      end
    end
  end

  // Counters and registered strobes; a partial bit on stop produces no pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      bit_idx    <= '0;
      clk_bps    <= 1'b0;
      bit_end    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      clk_bps    <= at_half;
      bit_end    <= at_wrap;
      frame_done <= at_wrap && at_last;
    end
  end

`ifdef BAUD_OVS16_EN
  // Oversample divisor per entry: ((DIV+1)>>4) - 1
  localparam logic [CNT_W-1:0] OVS_9600   = CNT_W'((CLK_HZ / 9600) / 16 - 1);
  localparam logic [CNT_W-1:0] OVS_19200  = CNT_W'((CLK_HZ / 19200) / 16 - 1);
  localparam logic [CNT_W-1:0] OVS_38400  = CNT_W'((CLK_HZ / 38400) / 16 - 1);
  localparam logic [CNT_W-1:0] OVS_57600  = CNT_W'((CLK_HZ / 57600) / 16 - 1);
  localparam logic [CNT_W-1:0] OVS_115200 = CNT_W'((CLK_HZ / 115200) / 16 - 1);

  logic [CNT_W-1:0] ovs_sel, ovs_r, ovs_cnt;

  // Oversample divisor lookup, mirrors the main table
  always_comb begin
    ovs_sel = OVS_9600;
    case (baud_sel)
      3'd1:    ovs_sel = OVS_19200;
      3'd2:    ovs_sel = OVS_38400;
      3'd3:    ovs_sel = OVS_57600;
      3'd4:    ovs_sel = OVS_115200;
      default: ovs_sel = OVS_9600;
    endcase
  end

  // 16x counter: cleared with the main counter and re-phased at every bit wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      ovs_r   <= '0;
      ovs_cnt <= '0;
      os_tick <= 1'b0;
    end else begin
      if (start_evt) ovs_r <= ovs_sel;
      if (!counting || at_wrap || (ovs_cnt == ovs_r)) ovs_cnt <= '0;
      else                                            ovs_cnt <= ovs_cnt + ONE_C;
      os_tick <= counting && (ovs_cnt == ovs_r);
    end
  end
`else
  assign os_tick = 1'b0;
`endif

endmodule

// File: tb/tb_baud_gen_sel.sv
// Bench for baud_gen_sel at 50 MHz: directed runs over the baud table with a timing model
// derived from elapsed run time, plus hand-computed pulse positions and spacings.
module tb_baud_gen_sel;

  localparam int CLK_HZ     = 50_000_000;
  localparam int FRAME_BITS = 10;
`ifdef BAUD_OVS16_EN
  localparam bit OVS_EN = 1'b1;
`else
  localparam bit OVS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       bps_start;
  logic [2:0] baud_sel;
  logic       clk_bps, bit_end, frame_done, os_tick;
  logic [3:0] bit_idx;

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc   = 0;

  baud_gen_sel #(.CLK_HZ(CLK_HZ), .CNT_W(16), .FRAME_BITS(FRAME_BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .bps_start  (bps_start),
    .baud_sel   (baud_sel),
    .clk_bps    (clk_bps),
    .bit_end    (bit_end),
    .frame_done (frame_done),
    .bit_idx    (bit_idx),
    .os_tick    (os_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Bit period in clocks for a baud_sel code
  function automatic longint period_of(input logic [2:0] sel);
    longint baud;
    case (sel)
      3'd1:    baud = 19200;
      3'd2:    baud = 38400;
      3'd3:    baud = 57600;
      3'd4:    baud = 115200;
      default: baud = 9600;
    endcase
    return CLK_HZ / baud;
  endfunction

  // Model: outputs follow from how many counting edges have elapsed since the run began
  bit        m_run   = 1'b0;
  bit        m_valid = 1'b0;
  longint    m_elapsed = 0;
  longint    m_period  = 1;
  logic [7:0] exp_vec = 8'h00;

  always @(posedge clk) begin
    longint pos, bitn, idx;
    bit e_bps, e_end, e_fd, e_os;
    cyc++;
    exp_vec = 8'h00;
    if (rst) begin
      m_run   = 1'b0;
      m_valid = 1'b1;
    end else if (!m_run) begin
      if (bps_start) begin
        m_run     = 1'b1;
        m_elapsed = 0;
        m_period  = period_of(baud_sel);
      end
    end else if (!bps_start) begin
      m_run = 1'b0;
    end else begin
      pos   = m_elapsed % m_period;
      bitn  = m_elapsed / m_period;
      e_bps = (pos == (m_period - 1) / 2);
      e_end = (pos == m_period - 1);
      e_fd  = e_end && ((bitn % FRAME_BITS) == FRAME_BITS - 1);
      e_os  = OVS_EN && (((pos + 1) % (m_period / 16)) == 0);
      idx   = ((m_elapsed + 1) / m_period) % FRAME_BITS;
      exp_vec = {e_bps, e_end, e_fd, e_os, 4'(idx)};
      m_elapsed++;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_valid)
      check("outputs_vs_model", {56'd0, clk_bps, bit_end, frame_done, os_tick, bit_idx}, {56'd0, exp_vec});
  end

  // Wait for a strobe (0 clk_bps, 1 bit_end, 2 frame_done, 3 os_tick); waited = cycles, -1 on timeout
  task automatic wait_for(input int which, input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((which == 0 && clk_bps === 1'b1) || (which == 1 && bit_end === 1'b1) ||
          (which == 2 && frame_done === 1'b1) || (which == 3 && os_tick === 1'b1)) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic start_run(input logic [2:0] sel);
    baud_sel  = sel;
    bps_start = 1'b1;
  endtask

  task automatic stop_run();
    bps_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  logic [2:0] sweep_sel [4] = '{3'd1, 3'd2, 3'd3, 3'd6};
  int         sweep_exp [4] = '{1303, 652, 435, 2605};

  initial begin
    int     w, n_bps, n_fd, n_strb, last;
    longint t;
    logic [3:0] prev_idx;

    rst = 1'b1; bps_start = 1'b1; baud_sel = 3'd0;

    // T1: reset held with bps_start high
    repeat (3) begin
      @(negedge clk);
      check("t1_reset_outputs", {clk_bps, bit_end, frame_done, os_tick, bit_idx}, 8'h00);
    end
    rst = 1'b0; bps_start = 1'b0;
    repeat (3) @(negedge clk);

    // T2: 9600 baud timing
    start_run(3'd0);
    wait_for(0, 3000, w);
    check("t2_first_clk_bps", w, 2605);
    t = cyc;
    wait_for(1, 3000, w);
    check("t2_bps_to_bit_end", cyc - t, 2604);
    wait_for(0, 3000, w);
    check("t2_bps_spacing", cyc - t, 5208);
    t = cyc;
    wait_for(0, 6000, w);
    check("t2_bps_spacing_2", cyc - t, 5208);
    stop_run();

    // Remaining table entries, including an out-of-range code
    for (int k = 0; k < 4; k++) begin
      start_run(sweep_sel[k]);
      wait_for(0, 3000, w);
      check("sweep_first_clk_bps", w, sweep_exp[k]);
      stop_run();
    end

    // T3: 115200 baud, two back-to-back frames
    start_run(3'd4);
    n_bps = 0; n_fd = 0; last = 0; prev_idx = 4'd0;
    for (int i = 1; i <= 8681; i++) begin
      @(negedge clk);
      if (clk_bps === 1'b1) begin
        n_bps++;
        if (last != 0) check("t3_bps_spacing", i - last, 434);
        last = i;
      end
      if (frame_done === 1'b1) begin
        n_fd++;
        check("t3_fd_bit_idx_before", prev_idx, 9);
        check("t3_fd_bit_idx_after", bit_idx, 0);
        check("t3_fd_with_bit_end", bit_end, 1);
      end
      prev_idx = bit_idx;
    end
    check("t3_clk_bps_count", n_bps, 20);
    check("t3_frame_done_count", n_fd, 2);
    stop_run();

    // T4: baud_sel change mid-run ignored until restart
    start_run(3'd4);
    wait_for(0, 500, w);
    check("t4_first_clk_bps", w, 218);
    baud_sel = 3'd0;
    wait_for(0, 1000, w);
    check("t4_period_held", w, 434);
    wait_for(0, 1000, w);
    check("t4_period_held_2", w, 434);
    stop_run();
    bps_start = 1'b1;
    wait_for(0, 3000, w);
    check("t4_restart_first_clk_bps", w, 2605);
    wait_for(0, 6000, w);
    check("t4_restart_period", w, 5208);
    stop_run();

    // T5: stop in the middle of bit 3 (cnt=100), then restart
    start_run(3'd4);
    repeat (1403) @(negedge clk);
    check("t5_bit_idx_before_stop", bit_idx, 3);
    bps_start = 1'b0;
    @(negedge clk);
    check("t5_bit_idx_after_stop", bit_idx, 0);
    n_strb = 0;
    repeat (1000) begin
      @(negedge clk);
      if (clk_bps !== 1'b0 || bit_end !== 1'b0 || frame_done !== 1'b0 || os_tick !== 1'b0) n_strb++;
    end
    check("t5_no_strobes_when_idle", n_strb, 0);
    bps_start = 1'b1;
    wait_for(0, 500, w);
    check("t5_restart_first_clk_bps", w, 218);
    stop_run();

    // T6: oversample tick
    start_run(3'd4);
`ifdef BAUD_OVS16_EN
    wait_for(3, 100, w);
    check("t6_first_os_tick", w, 28);
    for (int j = 0; j < 15; j++) begin
      wait_for(3, 100, w);
      check("t6_os_tick_spacing", w, 27);
    end
    wait_for(3, 100, w);
    check("t6_os_tick_rephase", w, 29);
`else
    n_strb = 0;
    repeat (1000) begin
      @(negedge clk);
      if (os_tick !== 1'b0) n_strb++;
    end
    check("t6_os_tick_tied_low", n_strb, 0);
`endif
    stop_run();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
